// File: rtl/bcrypt_axi4_burst_slave.sv
// AXI4 burst slave fronting the Bcrypt key/salt/hash staging RAM; one outstanding burst per direction.
// Optional macro BCRYPT_AXI_SLV_WRAP_EN enables WRAP bursts (len 1/3/7/15); without it WRAP gets SLVERR.
module bcrypt_axi4_burst_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);
  localparam int WA    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WA;
  localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Any burst that cannot be served faithfully: non-word size, reserved type, or unsupported WRAP.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [1:0] lo);
    logic wrap_bad;
    wrap_bad = !((len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) && lo == 2'b00);
`ifndef BCRYPT_AXI_SLV_WRAP_EN
    wrap_bad = 1'b1;
`endif
    return (size != SIZE_WORD) || (burst == 2'b11) || (burst == B_WRAP && wrap_bad);
  endfunction

  // ---------------- write channel ----------------
  wstate_t wstate, wstate_nxt;
  logic [C_S_AXI_ID_WIDTH-1:0] wid;
  logic [WA-1:0] waddr;
  logic [7:0]    wlen, wcnt;
  logic [1:0]    wburst;
  logic          werr, wstore, aw_hs, w_hs;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) wstate <= W_IDLE;
    else                wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt      = wstate;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        s00_axi_awready = !s00_axi_areset;
        if (s00_axi_awvalid) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s00_axi_wready = !s00_axi_areset;
        if (s00_axi_wvalid && wcnt == wlen) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s00_axi_bvalid = !s00_axi_areset;
        if (s00_axi_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  assign s00_axi_bid   = wid;
  assign s00_axi_bresp = (s00_axi_bvalid && werr) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wid <= '0; waddr <= '0; wlen <= '0; wcnt <= '0; wburst <= '0; werr <= 1'b0; wstore <= 1'b0;
    end else begin
      if (aw_hs) begin
        wid    <= s00_axi_awid;
        waddr  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        wlen   <= s00_axi_awlen;
        wburst <= s00_axi_awburst;
        wcnt   <= '0;
        werr   <= burst_err(s00_axi_awsize, s00_axi_awburst, s00_axi_awlen, s00_axi_awaddr[1:0]);
        wstore <= !burst_err(s00_axi_awsize, s00_axi_awburst, s00_axi_awlen, s00_axi_awaddr[1:0]);
      end
      if (w_hs) begin
        wcnt <= wcnt + 8'd1;
        werr <= werr | (s00_axi_wlast != (wcnt == wlen));
        case (wburst)
          B_FIXED: waddr <= waddr;
`ifdef BCRYPT_AXI_SLV_WRAP_EN
          B_WRAP:  waddr <= (waddr & ~WA'(wlen)) | ((waddr + 1'b1) & WA'(wlen));
`endif
          default: waddr <= waddr + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (w_hs && wstore)
      for (int b = 0; b < NB; b++)
        if (s00_axi_wstrb[b]) mem[waddr][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
  end

  // ---------------- read channel ----------------
  rstate_t rstate, rstate_nxt;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q;
  logic [WA-1:0] raddr;
  logic [7:0]    rlen, ricnt;
  logic [1:0]    rburst;
  logic          rbad, rdone, ar_hs, issue, pop;
  // Two-entry skid loaded straight from the RAM: keeps beats back-to-back under rready stalls.
  logic [C_S_AXI_DATA_WIDTH-1:0] sk_dat [2];
  logic          sk_last [2];
  logic          sk_err [2];
  logic          sk_wp, sk_rp;
  logic [1:0]    sk_cnt;

  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign pop   = s00_axi_rvalid && s00_axi_rready;
  assign issue = (rstate == R_DATA) && !rdone && (sk_cnt != 2'd2 || pop);

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) rstate <= R_IDLE;
    else                rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt      = rstate;
    s00_axi_arready = 1'b0;
    case (rstate)
      R_IDLE: begin
        s00_axi_arready = !s00_axi_areset;
        if (s00_axi_arvalid) rstate_nxt = R_DATA;
      end
      R_DATA: if (pop && sk_last[sk_rp]) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign s00_axi_rvalid = (sk_cnt != 2'd0) && !s00_axi_areset;
  assign s00_axi_rid    = rid_q;
  assign s00_axi_rdata  = s00_axi_rvalid ? sk_dat[sk_rp] : '0;
  assign s00_axi_rlast  = s00_axi_rvalid && sk_last[sk_rp];
  assign s00_axi_rresp  = (s00_axi_rvalid && sk_err[sk_rp]) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rid_q <= '0; raddr <= '0; rlen <= '0; ricnt <= '0; rburst <= '0;
      rbad <= 1'b0; rdone <= 1'b0; sk_wp <= 1'b0; sk_rp <= 1'b0; sk_cnt <= 2'd0;
    end else begin
      if (ar_hs) begin
        rid_q  <= s00_axi_arid;
        raddr  <= s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
        rlen   <= s00_axi_arlen;
        rburst <= s00_axi_arburst;
        ricnt  <= '0;
        rdone  <= 1'b0;
        rbad   <= burst_err(s00_axi_arsize, s00_axi_arburst, s00_axi_arlen, s00_axi_araddr[1:0]);
      end
      if (issue) begin
        sk_wp <= ~sk_wp;
        ricnt <= ricnt + 8'd1;
        if (ricnt == rlen) rdone <= 1'b1;
        case (rburst)
          B_FIXED: raddr <= raddr;
`ifdef BCRYPT_AXI_SLV_WRAP_EN
          B_WRAP:  raddr <= (raddr & ~WA'(rlen)) | ((raddr + 1'b1) & WA'(rlen));
`endif
          default: raddr <= raddr + 1'b1;
        endcase
      end
      if (pop) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + {1'b0, issue} - {1'b0, pop};
    end
  end

  // RAM sampled at the clock edge, so a same-cycle write to this word is not yet visible.
  always_ff @(posedge s00_axi_aclk) begin
    if (issue) begin
      sk_dat[sk_wp]  <= rbad ? '0 : mem[raddr];
      sk_last[sk_wp] <= (ricnt == rlen);
      sk_err[sk_wp]  <= rbad;
    end
  end
endmodule
